// File: rtl/pps_sched_trigger.sv
// PPS-disciplined time base (second mod 60 + cycle count) with a scheduled fixed-width trigger.
// Build option: define PPS_SCHED_REPEAT_EN to re-arm the trigger for the same count every second.
module pps_sched_trigger #(
    parameter int unsigned UTC_SECONDS_WIDTH       = 6,
    parameter int unsigned COUNT_LAST_SECOND_WIDTH = 26,
    parameter int unsigned NOMINAL_CYCLES_PER_SEC  = 61_440_000,
    parameter int unsigned MARGIN                  = 5,
    parameter int unsigned TRIGGER_WIDTH           = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               pps,
    input  logic                               sched_valid,
    output logic                               sched_ready,
    input  logic [UTC_SECONDS_WIDTH-1:0]       sched_utc_seconds,
    input  logic [COUNT_LAST_SECOND_WIDTH-1:0] sched_clk_count,
    input  logic                               cancel,
    output logic                               trigger,
    output logic                               late,
    output logic                               armed,
    output logic                               holdover,
    output logic [UTC_SECONDS_WIDTH-1:0]       cur_utc_seconds,
    output logic [COUNT_LAST_SECOND_WIDTH-1:0] cur_clk_counter
);

    localparam int unsigned SW = UTC_SECONDS_WIDTH;
    localparam int unsigned CW = COUNT_LAST_SECOND_WIDTH;
    localparam int unsigned FW = $clog2(TRIGGER_WIDTH + 1);

    localparam logic [CW-1:0] CNT_LIMIT   = CW'(NOMINAL_CYCLES_PER_SEC + MARGIN);
    localparam logic [CW-1:0] CNT_WRAP    = CW'(NOMINAL_CYCLES_PER_SEC + MARGIN - 1);
    localparam logic [CW-1:0] CNT_RESTART = CW'(MARGIN);
    localparam logic [SW-1:0] SEC_MAX     = SW'(59);
    localparam logic [FW-1:0] FIRE_LAST   = FW'(TRIGGER_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ARMED, FIRE} state_t;

    state_t        state, state_nx;
    logic          pps_s1, pps_s2, pps_d;
    logic          started;
    logic          pps_rise, fab_tick, sec_tick;
    logic [SW-1:0] sec_next;
    logic [SW-1:0] tgt_sec, tgt_sec_nx;
    logic [CW-1:0] tgt_cnt, tgt_cnt_nx;
    logic [FW-1:0] fire_cnt, fire_cnt_nx;
    logic          late_nx;
    logic          target_bad, target_hit;

    assign pps_rise = pps_s2 & ~pps_d;
    assign fab_tick = started & ~pps_rise & (cur_clk_counter >= CNT_WRAP);
    assign sec_tick = pps_rise | fab_tick;
    assign sec_next = (cur_utc_seconds >= SEC_MAX) ? '0 : cur_utc_seconds + SW'(1);

    // PPS synchronizer and local time base; a missing PPS is fabricated after the margin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pps_s1          <= 1'b0;
            pps_s2          <= 1'b0;
            pps_d           <= 1'b0;
            started         <= 1'b0;
            holdover        <= 1'b0;
            cur_utc_seconds <= '0;
            cur_clk_counter <= '0;
        end else begin
            pps_s1 <= pps;
            pps_s2 <= pps_s1;
            pps_d  <= pps_s2;
            if (pps_rise) begin
                started         <= 1'b1;
                holdover        <= 1'b0;
                cur_clk_counter <= '0;
                cur_utc_seconds <= sec_next;
            end else if (fab_tick) begin
                holdover        <= 1'b1;
                cur_clk_counter <= CNT_RESTART;
                cur_utc_seconds <= sec_next;
            end else if (started) begin
                cur_clk_counter <= cur_clk_counter + CW'(1);
            end
        end
    end

    // A target equal to or behind the current instant of the current second cannot be met.
    assign target_bad = (sched_clk_count >= CNT_LIMIT) || (sched_utc_seconds > SEC_MAX) ||
                        ((sched_utc_seconds == cur_utc_seconds) && (sched_clk_count <= cur_clk_counter));
    assign target_hit = (cur_utc_seconds == tgt_sec) && (cur_clk_counter == tgt_cnt);

`ifdef PPS_SCHED_REPEAT_EN
    logic [SW-1:0] tgt_sec_inc;
    assign tgt_sec_inc = (tgt_sec >= SEC_MAX) ? '0 : tgt_sec + SW'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tgt_sec  <= '0;
            tgt_cnt  <= '0;
            fire_cnt <= '0;
            late     <= 1'b0;
        end else begin
            state    <= state_nx;
            tgt_sec  <= tgt_sec_nx;
            tgt_cnt  <= tgt_cnt_nx;
            fire_cnt <= fire_cnt_nx;
            late     <= late_nx;
        end
    end

    // Scheduler: accept/check target, wait for match, hold trigger for TRIGGER_WIDTH cycles.
    always_comb begin
        state_nx    = state;
        tgt_sec_nx  = tgt_sec;
        tgt_cnt_nx  = tgt_cnt;
        fire_cnt_nx = fire_cnt;
        late_nx     = 1'b0;
        unique case (state)
            IDLE: begin
                if (sched_valid && started && !cancel) begin
                    tgt_sec_nx = sched_utc_seconds;
                    tgt_cnt_nx = sched_clk_count;
                    if (target_bad) late_nx  = 1'b1;
                    else            state_nx = ARMED;
                end
            end
            ARMED: begin
                if (cancel) begin
                    state_nx = IDLE;
                end else if (target_hit) begin
                    state_nx    = FIRE;
                    fire_cnt_nx = '0;
                end else if (sec_tick && (cur_utc_seconds == tgt_sec)) begin
                    late_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            FIRE: begin
                if (cancel) begin
                    state_nx = IDLE;
                end else if (fire_cnt == FIRE_LAST) begin
`ifdef PPS_SCHED_REPEAT_EN
                    state_nx   = ARMED;
                    tgt_sec_nx = tgt_sec_inc;
`else
                    state_nx   = IDLE;
`endif
                end else begin
                    fire_cnt_nx = fire_cnt + FW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign trigger     = (state == FIRE);
    assign armed       = (state != IDLE);
    assign sched_ready = started && (state == IDLE);

endmodule

// File: tb/tb_pps_sched_trigger.sv
// Self-checking bench for pps_sched_trigger: directed scenarios plus randomized traffic
// checked every cycle against a cycle-numbered behavioural model.
`timescale 1ns/1ps
module tb_pps_sched_trigger;
    localparam int NOM = 100;
    localparam int MRG = 5;
    localparam int TW  = 4;
    localparam int SW  = 6;
    localparam int CW  = 26;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pps = 1'b0;
    logic          sched_valid = 1'b0;
    logic          cancel = 1'b0;
    logic [SW-1:0] sched_utc_seconds = '0;
    logic [CW-1:0] sched_clk_count = '0;
    logic          sched_ready, trigger, late, armed, holdover;
    logic [SW-1:0] cur_utc_seconds;
    logic [CW-1:0] cur_clk_counter;
    logic [36:0]   dut_vec;

    int total = 0;
    int bad = 0;
    bit pps_en = 1'b0;
    int pps_ctr = 0;

    always #5 clk = ~clk;

    pps_sched_trigger #(
        .UTC_SECONDS_WIDTH(SW), .COUNT_LAST_SECOND_WIDTH(CW),
        .NOMINAL_CYCLES_PER_SEC(NOM), .MARGIN(MRG), .TRIGGER_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst), .pps(pps),
        .sched_valid(sched_valid), .sched_ready(sched_ready),
        .sched_utc_seconds(sched_utc_seconds), .sched_clk_count(sched_clk_count),
        .cancel(cancel), .trigger(trigger), .late(late), .armed(armed), .holdover(holdover),
        .cur_utc_seconds(cur_utc_seconds), .cur_clk_counter(cur_clk_counter)
    );

    assign dut_vec = {trigger, late, armed, holdover, sched_ready, cur_utc_seconds, cur_clk_counter};

    // Reference model: trigger is a window of absolute cycle numbers, pps seen three edges late.
    bit     h1, h2, h3, m_started, m_hold, m_pending, m_late;
    bit     rise, tick, firing;
    int     m_sec, m_cnt, m_tsec, m_tcnt;
    longint cyc, trig_end;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h1 = 0; h2 = 0; h3 = 0;
            m_started = 0; m_hold = 0; m_pending = 0; m_late = 0;
            m_sec = 0; m_cnt = 0; m_tsec = 0; m_tcnt = 0;
            cyc = 0; trig_end = -10;
        end else begin
            rise   = h2 && !h3;
            tick   = rise || (m_started && m_cnt >= NOM + MRG - 1);
            firing = (cyc <= trig_end);
            m_late = 0;
            if (firing) begin
                if (cancel) begin
                    m_pending = 0;
                    trig_end  = cyc;
                end else if (cyc == trig_end) begin
`ifdef PPS_SCHED_REPEAT_EN
                    m_tsec = (m_tsec + 1) % 60;
`else
                    m_pending = 0;
`endif
                end
            end else if (m_pending) begin
                if (cancel) m_pending = 0;
                else if (m_sec == m_tsec && m_cnt == m_tcnt) trig_end = cyc + TW;
                else if (tick && m_sec == m_tsec) begin
                    m_late = 1;
                    m_pending = 0;
                end
            end else if (sched_valid && m_started && !cancel) begin
                if (int'(sched_clk_count) >= NOM + MRG || int'(sched_utc_seconds) > 59 ||
                    (int'(sched_utc_seconds) == m_sec && int'(sched_clk_count) <= m_cnt)) begin
                    m_late = 1;
                end else begin
                    m_pending = 1;
                    m_tsec = int'(sched_utc_seconds);
                    m_tcnt = int'(sched_clk_count);
                end
            end
            if (rise) begin
                m_started = 1; m_cnt = 0; m_hold = 0; m_sec = (m_sec + 1) % 60;
            end else if (m_started) begin
                if (m_cnt >= NOM + MRG - 1) begin
                    m_cnt = MRG; m_hold = 1; m_sec = (m_sec + 1) % 60;
                end else begin
                    m_cnt++;
                end
            end
            h3 = h2; h2 = h1; h1 = pps;
            cyc++;
        end
    end

    function automatic logic [36:0] exp_vec();
        return {1'(cyc <= trig_end), m_late, m_pending, m_hold, 1'(m_started && !m_pending),
                SW'(m_sec), CW'(m_cnt)};
    endfunction

    // Advance to the next falling edge and drive the periodic PPS source.
    task automatic step();
        @(negedge clk);
        if (pps_en) begin
            pps = (pps_ctr == 0);
            pps_ctr = (pps_ctr + 1) % NOM;
        end else begin
            pps = 1'b0;
        end
    endtask

    task automatic schedule(input int s, input int c);
        sched_valid = 1'b1;
        sched_utc_seconds = SW'(s);
        sched_clk_count = CW'(c);
        step();
        sched_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) step();
        total++;
        if (dut_vec !== '0) begin bad++; $display("FAIL reset_zero: got %h want 0", dut_vec); end
        total++;
        if (dut_vec !== exp_vec()) begin bad++; $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec()); end
        rst = 1'b0;
    endtask

    task automatic test_prestart();
        sched_valid = 1'b1; sched_utc_seconds = 6'd1; sched_clk_count = 26'd5;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (sched_ready !== 1'b0 || armed !== 1'b0 || cur_clk_counter !== '0)
                begin bad++; $display("FAIL prestart: ready=%b armed=%b cnt=%0d want 0/0/0", sched_ready, armed, cur_clk_counter); end
        end
        sched_valid = 1'b0;
        pps_en = 1'b1; pps_ctr = 0;
        repeat (3) step();
        total++;
        if (cur_utc_seconds !== 6'd0 || sched_ready !== 1'b0)
            begin bad++; $display("FAIL sync_early: sec=%0d ready=%b want 0/0", cur_utc_seconds, sched_ready); end
        step();
        total++;
        if (cur_utc_seconds !== 6'd1 || cur_clk_counter !== '0 || sched_ready !== 1'b1)
            begin bad++; $display("FAIL first_pps: sec=%0d cnt=%0d ready=%b want 1/0/1", cur_utc_seconds, cur_clk_counter, sched_ready); end
    endtask

    task automatic test_normal();
        int n = 0;
        int tcount = 0;
        while (!(m_sec == 1 && m_cnt == 10) && n < 300) begin step(); n++; end
        schedule(2, 20);
        total++;
        if (armed !== 1'b1 || sched_ready !== 1'b0) begin bad++; $display("FAIL arm: armed=%b ready=%b want 1/0", armed, sched_ready); end
        schedule(5, 5);
        n = 0;
        while (!(m_sec == 2 && m_cnt == 50) && n < 300) begin
            total++;
            if (dut_vec !== exp_vec()) begin bad++; $display("FAIL normal_model@%0t: got %h want %h", $time, dut_vec, exp_vec()); end
            if (trigger === 1'b1) begin
                tcount++;
                total++;
                if (cur_utc_seconds !== 6'd2 || cur_clk_counter !== CW'(20 + tcount))
                    begin bad++; $display("FAIL trig_pos: sec=%0d cnt=%0d want 2/%0d", cur_utc_seconds, cur_clk_counter, 20 + tcount); end
            end
`ifdef PPS_SCHED_REPEAT_EN
            cancel = (tcount == TW && trigger === 1'b0 && cancel == 1'b0 && armed === 1'b1);
`endif
            step(); n++;
        end
        cancel = 1'b0;
        total++;
        if (tcount != TW || armed !== 1'b0) begin bad++; $display("FAIL trig_width: cycles=%0d armed=%b want %0d/0", tcount, armed, TW); end
        if (n >= 300) begin bad++; $display("FAIL normal_timeout: waited %0d cycles", n); end
    endtask

    task automatic test_late();
        schedule(2, 30);
        total++;
        if (late !== 1'b1 || armed !== 1'b0) begin bad++; $display("FAIL late_past: late=%b armed=%b want 1/0", late, armed); end
        schedule(2, 120);
        total++;
        if (late !== 1'b1 || armed !== 1'b0) begin bad++; $display("FAIL late_count: late=%b armed=%b want 1/0", late, armed); end
        schedule(60, 10);
        total++;
        if (late !== 1'b1 || armed !== 1'b0) begin bad++; $display("FAIL late_sec: late=%b armed=%b want 1/0", late, armed); end
        step();
        total++;
        if (late !== 1'b0 || dut_vec !== exp_vec()) begin bad++; $display("FAIL late_pulse: got %h want %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_missing_pps();
        int n = 0;
        pps_en = 1'b0;
        while (m_cnt != 104 && n < 300) begin step(); n++; end
        total++;
        if (cur_clk_counter !== 26'd104 || holdover !== 1'b0)
            begin bad++; $display("FAIL pre_fab: cnt=%0d hold=%b want 104/0", cur_clk_counter, holdover); end
        step();
        total++;
        if (cur_clk_counter !== 26'd5 || cur_utc_seconds !== 6'd3 || holdover !== 1'b1)
            begin bad++; $display("FAIL fab: cnt=%0d sec=%0d hold=%b want 5/3/1", cur_clk_counter, cur_utc_seconds, holdover); end
        pps_en = 1'b1; pps_ctr = 0;
        repeat (4) begin
            step();
            total++;
            if (dut_vec !== exp_vec()) begin bad++; $display("FAIL resync_model: got %h want %h", dut_vec, exp_vec()); end
        end
        total++;
        if (cur_clk_counter !== '0 || cur_utc_seconds !== 6'd4 || holdover !== 1'b0)
            begin bad++; $display("FAIL resync: cnt=%0d sec=%0d hold=%b want 0/4/0", cur_clk_counter, cur_utc_seconds, holdover); end
    endtask

    task automatic test_missed();
        int ts = (m_sec + 1) % 60;
        int n = 0;
        schedule(ts, 102);
        while (late !== 1'b1 && n < 300) begin
            total++;
            if (dut_vec !== exp_vec()) begin bad++; $display("FAIL missed_model@%0t: got %h want %h", $time, dut_vec, exp_vec()); end
            step(); n++;
        end
        total++;
        if (n >= 300 || cur_clk_counter !== '0 || cur_utc_seconds !== SW'((ts + 1) % 60) || armed !== 1'b0)
            begin bad++; $display("FAIL missed: n=%0d cnt=%0d sec=%0d armed=%b want cnt 0 sec %0d armed 0", n, cur_clk_counter, cur_utc_seconds, armed, (ts + 1) % 60); end
        step();
        total++;
        if (late !== 1'b0) begin bad++; $display("FAIL missed_pulse: late=%b want 0", late); end
    endtask

    task automatic test_cancel();
        int ts = (m_sec + 1) % 60;
        int n = 0;
        schedule(ts, 20);
        while (!(m_sec == ts && m_cnt == 20) && n < 300) begin step(); n++; end
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        total++;
        if (n >= 300 || trigger !== 1'b0 || armed !== 1'b0 || late !== 1'b0)
            begin bad++; $display("FAIL cancel_match: n=%0d trig=%b armed=%b late=%b want 0/0/0", n, trigger, armed, late); end
        repeat (6) begin
            step();
            total++;
            if (trigger !== 1'b0 || dut_vec !== exp_vec()) begin bad++; $display("FAIL cancel_after: got %h want %h", dut_vec, exp_vec()); end
        end
        cancel = 1'b1; sched_valid = 1'b1;
        sched_utc_seconds = SW'((m_sec + 2) % 60); sched_clk_count = 26'd7;
        step();
        cancel = 1'b0; sched_valid = 1'b0;
        total++;
        if (armed !== 1'b0 || late !== 1'b0) begin bad++; $display("FAIL cancel_idle: armed=%b late=%b want 0/0", armed, late); end
    endtask

`ifdef PPS_SCHED_REPEAT_EN
    task automatic test_repeat();
        int ts = (m_sec + 1) % 60;
        int hits = 0;
        int n = 0;
        schedule(ts, 20);
        while (hits < 3 && n < 400) begin
            total++;
            if (dut_vec !== exp_vec()) begin bad++; $display("FAIL repeat_model@%0t: got %h want %h", $time, dut_vec, exp_vec()); end
            if (trigger === 1'b1 && cur_clk_counter == 26'd21) begin
                total++;
                if (cur_utc_seconds !== SW'((ts + hits) % 60))
                    begin bad++; $display("FAIL repeat_sec: sec=%0d want %0d", cur_utc_seconds, (ts + hits) % 60); end
                hits++;
            end
            step(); n++;
        end
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        total++;
        if (hits != 3 || armed !== 1'b0) begin bad++; $display("FAIL repeat: hits=%0d armed=%b want 3/0", hits, armed); end
    endtask
`endif

    task automatic test_rst_fire();
        int ts = (m_sec + 1) % 60;
        int n = 0;
        schedule(ts, 20);
        while (!(m_sec == ts && m_cnt == 22) && n < 300) begin step(); n++; end
        total++;
        if (trigger !== 1'b1) begin bad++; $display("FAIL pre_rst_trig: trig=%b want 1", trigger); end
        #2 rst = 1'b1;
        #1;
        total++;
        if (dut_vec !== '0) begin bad++; $display("FAIL rst_fire: got %h want 0", dut_vec); end
        repeat (2) step();
        rst = 1'b0;
        total++;
        if (dut_vec !== exp_vec()) begin bad++; $display("FAIL rst_model: got %h want %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            total++;
            if (dut_vec !== exp_vec()) begin bad++; $display("FAIL random@%0t: got %h want %h", $time, dut_vec, exp_vec()); end
            sched_valid = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 2))
                0: sched_utc_seconds = SW'(m_sec);
                1: sched_utc_seconds = SW'((m_sec + 1) % 60);
                default: sched_utc_seconds = SW'($urandom_range(0, 63));
            endcase
            sched_clk_count = CW'($urandom_range(0, 110));
            cancel = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 399) == 0) pps_en = !pps_en;
            step();
        end
        sched_valid = 1'b0; cancel = 1'b0; pps_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_prestart();
        test_normal();
        test_late();
        test_missing_pps();
        test_missed();
        test_cancel();
`ifdef PPS_SCHED_REPEAT_EN
        test_repeat();
`endif
        test_rst_fire();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pps_sched_trigger.md
Name: pps_sched_trigger

Overview:
- Transmit-side counterpart of the PPS timestamp capture.
- Keeps a local PPS-disciplined time base: UTC second modulo 60, plus clock count since the last PPS.
- Accepts a scheduled time (second, clock count) over a valid/ready handshake and emits a trigger pulse of fixed width when the local time reaches that point.
- Sits between the control/DMA logic and the TX path, so transmissions start at exact PPS-referenced instants.

Parameters:
- UTC_SECONDS_WIDTH, 6, width of second fields (values 0..59).
- COUNT_LAST_SECOND_WIDTH, 26, width of clock-count fields.
- NOMINAL_CYCLES_PER_SEC, 61_440_000, expected clk cycles per PPS period.
- MARGIN, 5, extra cycles tolerated before a missing PPS is fabricated.
- TRIGGER_WIDTH, 4, trigger high time in clk cycles (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pps  in  1  asynchronous PPS input
- sched_valid  in  1  schedule request valid
- sched_ready  out  1  block can accept a schedule
- sched_utc_seconds  in  UTC_SECONDS_WIDTH  target second
- sched_clk_count  in  COUNT_LAST_SECOND_WIDTH  target count within the second
- cancel  in  1  abort a pending or active trigger
- trigger  out  1  scheduled pulse
- late  out  1  one-cycle pulse: schedule rejected or missed
- armed  out  1  a schedule is pending
- holdover  out  1  time base is running on fabricated PPS
- cur_utc_seconds  out  UTC_SECONDS_WIDTH  local second
- cur_clk_counter  out  COUNT_LAST_SECOND_WIDTH  local count

Behaviour:
- Reset values: all outputs 0, state IDLE, started 0.
- PPS path:
  - 2-flop synchronizer plus edge-detect register; pps_rise is a 1-cycle strobe.
  - started sets on the first pps_rise. Before that the counters hold 0 and sched_ready stays 0.
- Time base, once started:
  - On pps_rise: count <= 0, second increments with wrap 59 -> 0, holdover <= 0.
  - Else if count >= NOMINAL_CYCLES_PER_SEC + MARGIN - 1: count <= MARGIN, second increments, holdover <= 1.
  - Else count increments by 1.
- Comparisons always use the register values of the current cycle (pre-update).
- FSM, IDLE:
  - sched_ready = started.
  - On sched_valid & sched_ready, the target is latched and checked:
    - If sched_clk_count >= NOMINAL_CYCLES_PER_SEC + MARGIN, or sched_utc_seconds > 59, or (sched_utc_seconds == current second and sched_clk_count <= current count): late pulses next cycle and the FSM stays in IDLE.
    - Otherwise -> ARMED next cycle, and armed = 1.
- Scheduling horizon is at most 59 s ahead. A target second that differs from the current second is always treated as a future second.
- FSM, ARMED:
  - If second == target second and count == target count: -> FIRE.
  - If a second increment occurs (real or fabricated) while second == target second, the target was not reached: late pulses, -> IDLE.
- FSM, FIRE:
  - trigger goes high the cycle after the match and stays high exactly TRIGGER_WIDTH cycles.
  - Then -> IDLE, with armed cleared on entry to IDLE.
- Latency: match cycle N -> trigger high in cycles N+1 .. N+TRIGGER_WIDTH.
- cancel in ARMED or FIRE: -> IDLE next cycle, trigger and armed low next cycle, no late pulse.
  - cancel beats a same-cycle match.
  - cancel in IDLE has no effect, and a same-cycle sched_valid is not accepted.
- sched_ready is 0 in ARMED and FIRE; sched_valid there is ignored.
- A PPS edge during FIRE does not shorten the trigger.
- Asynchronous rst at any time returns everything to reset values on the same edge.

Optional Feature:
- Macro: PPS_SCHED_REPEAT_EN.
- Defined:
  - FIRE returns to ARMED instead of IDLE, with target second = target second + 1 (mod 60) and the same target count. This gives a periodic trigger once per second.
  - armed stays 1 and sched_ready stays 0 until cancel or a missed-target late event.
- Undefined: one-shot only, exactly as in Behaviour.

Test Plan:
- Setup for all scenarios: NOMINAL_CYCLES_PER_SEC=100, MARGIN=5, TRIGGER_WIDTH=4.
1. Pre-start: sched_valid with no PPS yet -> sched_ready=0, no accept. First pps rise -> after 3-cycle sync, count=0 and second=1.
2. Normal schedule: at second 1, count 10, schedule (2, 20) -> armed=1; PPS at period 100 -> trigger high while count is 21..24 of second 2, then armed=0.
3. Late: at second 2, count 50, schedule (2, 30) -> late pulse 1 cycle, armed stays 0. Schedule (2, 120) -> rejected as late.
4. Missing PPS: withhold pps -> at count 104, count becomes 5, second increments, holdover=1. Next real pps -> count 0, holdover=0.
5. Missed target: schedule (3, 102), real PPS at count 99 -> late pulse at second rollover, FSM back to IDLE.
6. Cancel and reset: cancel asserted in the same cycle as the match -> no trigger. Assert rst during FIRE -> trigger=0 immediately, all outputs 0.
   - With PPS_SCHED_REPEAT_EN: schedule (2, 20) -> triggers at count 21 of seconds 2, 3, 4 until cancel.
